axis_block_avg_repeater: RTL and testbench
==========================================

Name: axis_block_avg_repeater

Overview:
- AXI-Stream reduction stage. It collects 2^ACC_COUNT_LOG input samples per block and emits one result per block, either the block sum or the block average (a power-of-two divide by shift).
- Each result is presented NUMBER_OF_REPETITIONS times on the output stream.
- Sits between a sample source and downstream per-block consumers, e.g. mean subtraction in the compressor pipeline.

Parameters:
- DATA_WIDTH, 16, input sample width.
- ACC_COUNT_LOG, 8, log2 of samples per block; valid range 1..16.
- IS_SIGNED, 0, 1 = samples are two's complement (sign-extend, arithmetic shift); 0 = unsigned (zero-extend, logical shift).
- OUTPUT_AVERAGE, 1, 1 = output is the average; 0 = output is the full sum.
- NUMBER_OF_REPETITIONS, 1, output beats per result; must be ≥1.
- OUT_WIDTH (localparam) = DATA_WIDTH if OUTPUT_AVERAGE, else DATA_WIDTH+ACC_COUNT_LOG.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset).
- input_valid  in  1  AXIS source valid.
- input_ready  out  1  AXIS sink ready.
- input_data  in  DATA_WIDTH  sample.
- output_valid  out  1  result valid.
- output_ready  in  1  downstream ready.
- output_data  out  OUT_WIDTH  sum or average.

Behaviour:
- Internal state:
  - accumulator, DATA_WIDTH+ACC_COUNT_LOG bits; a full block cannot overflow it.
  - sample counter, ACC_COUNT_LOG bits.
  - repetition counter.
  - result register.
  - FSM with two states: ACCUM and OUTPUT.
- Reset (rst=0 at an edge):
  - FSM goes to ACCUM; accumulator, counters and result register are cleared.
  - output_valid=0 and input_ready=0 while rst=0.
  - A reset mid-block or mid-repetition discards all partial state; no result is emitted.
- ACCUM state:
  - input_ready=1 and output_valid=0.
  - On each handshake (input_valid & input_ready), the accumulator adds the extended input_data and the counter increments.
  - On the handshake with counter = 2^ACC_COUNT_LOG−1:
    - the result register loads (accumulator + current sample) in sum mode, or that value shifted right by ACC_COUNT_LOG in average mode (floor; signed results round toward −inf);
    - accumulator and counter clear;
    - FSM goes to OUTPUT.
  - Latency: output_valid rises the cycle after the last sample is accepted.
- OUTPUT state:
  - output_valid=1, output_data = result register, input_ready=0.
  - Output is held stable while output_ready=0.
  - Each output handshake increments the repetition counter.
  - On the handshake where the counter = NUMBER_OF_REPETITIONS−1, the counter clears and the FSM returns to ACCUM; input_ready=1 in the next cycle.
- Sum mode output is the full-width sum (no truncation). Average output is the low DATA_WIDTH bits of the shifted sum, which always fit.
- input_valid gaps and output_ready stalls are allowed at any cycle without data loss or duplication.
- input_ready and output_valid are never high in the same cycle.

Optional Feature:
- Macro AXIS_BLOCK_AVG_ROUND_EN.
- When defined, in average mode only, 2^(ACC_COUNT_LOG−1) is added to the sum before the shift (round half up; half toward +inf for signed).
- When not defined, the shift truncates (floor).
- Sum mode is unaffected in both cases.

Test Plan:
- LOG=2, unsigned, avg, REP=1:
  - input 1,2,3,4 → single output 2 (3 with AXIS_BLOCK_AVG_ROUND_EN);
  - output_valid high exactly 1 cycle after sample 4 is accepted.
- LOG=2, IS_SIGNED=1, avg:
  - input −1,−2,−3,−4 → −3 (0xFFFD);
  - with round, −2 (0xFFFE).
- LOG=2, OUTPUT_AVERAGE=0, DATA_WIDTH=16:
  - input 0xFFFF ×4 → 18-bit output 0x3FFFC;
  - no overflow.
- REP=7, LOG=2, avg, input 10,20,30,40 → value 25 on exactly 7 output handshakes.
  - output_ready toggling randomly → still exactly 7 beats, data stable while stalled;
  - input_ready=0 throughout.
- Gapped input_valid plus output_ready=0 for 10 cycles after the result:
  - result held;
  - the next block is not accepted until the result drains;
  - the second block 5,5,5,5 → 5.
- Reset asserted after 2 of 4 samples, then block 8,8,8,8 → single output 8;
  - the partial block produces no output.

Source files
------------

// File: rtl/axis_block_avg_repeater.sv
// ---------------------------------------------------------------------------
// axis_block_avg_repeater
//
// AXI-Stream reduction stage. Collects 2^ACC_COUNT_LOG input samples per
// block and produces one result per block: either the full block sum or the
// block average (power-of-two divide by an arithmetic/logical right shift).
// Each result is presented NUMBER_OF_REPETITIONS times on the output stream
// before the next block is accepted.
//
// Optional feature macro: AXIS_BLOCK_AVG_ROUND_EN
//   defined     -> average mode adds 2^(ACC_COUNT_LOG-1) before the shift
//                  (round half up).
//   not defined -> average mode truncates (floor).
//   Sum mode is identical in both builds.
//
// Ports:
//   clk           in   1            clock, rising edge
//   rst           in   1            synchronous reset, active low
//   input_valid   in   1            source valid
//   input_ready   out  1            sink ready (high only while accumulating)
//   input_data    in   DATA_WIDTH   sample
//   output_valid  out  1            result valid (high only while repeating)
//   output_ready  in   1            downstream ready
//   output_data   out  OUT_WIDTH    block sum or block average
// ---------------------------------------------------------------------------
module axis_block_avg_repeater #(
  parameter int DATA_WIDTH            = 16,
  parameter int ACC_COUNT_LOG         = 8,
  parameter int IS_SIGNED             = 0,
  parameter int OUTPUT_AVERAGE        = 1,
  parameter int NUMBER_OF_REPETITIONS = 1,
  localparam int OUT_WIDTH = (OUTPUT_AVERAGE != 0) ? DATA_WIDTH
                                                   : DATA_WIDTH + ACC_COUNT_LOG
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  input_valid,
  output logic                  input_ready,
  input  logic [DATA_WIDTH-1:0] input_data,
  output logic                  output_valid,
  input  logic                  output_ready,
  output logic [OUT_WIDTH-1:0]  output_data
);

  localparam int ACC_WIDTH = DATA_WIDTH + ACC_COUNT_LOG;
  localparam int REP_WIDTH = (NUMBER_OF_REPETITIONS > 1) ? $clog2(NUMBER_OF_REPETITIONS) : 1;

  localparam logic [ACC_COUNT_LOG-1:0] CNT_LAST = '1;
  localparam logic [ACC_COUNT_LOG-1:0] CNT_ONE  = ACC_COUNT_LOG'(1);
  localparam logic [REP_WIDTH-1:0]     REP_LAST = REP_WIDTH'(NUMBER_OF_REPETITIONS - 1);
  localparam logic [REP_WIDTH-1:0]     REP_ONE  = REP_WIDTH'(1);

`ifdef AXIS_BLOCK_AVG_ROUND_EN
  // Half of the divisor; a full block plus this bias still fits ACC_WIDTH.
  localparam logic [ACC_WIDTH-1:0] ROUND_BIAS = ACC_WIDTH'(1) << (ACC_COUNT_LOG - 1);
`else
  localparam logic [ACC_WIDTH-1:0] ROUND_BIAS = '0;
`endif

  typedef enum logic {
    ST_ACCUM  = 1'b0,
    ST_OUTPUT = 1'b1
  } state_t;

  state_t                   r_state;
  logic [ACC_WIDTH-1:0]     r_acc;
  logic [ACC_COUNT_LOG-1:0] r_cnt;
  logic [REP_WIDTH-1:0]     r_rep;
  logic [OUT_WIDTH-1:0]     r_result;
  logic                     r_in_ready;
  logic                     r_out_valid;

  logic [ACC_WIDTH-1:0]     w_sample_ext;
  logic [ACC_WIDTH-1:0]     w_sum;
  logic [ACC_WIDTH-1:0]     w_biased;
  logic [ACC_WIDTH-1:0]     w_shifted;
  logic [OUT_WIDTH-1:0]     w_result;
  logic                     w_in_hs;
  logic                     w_out_hs;

  // The handshake flags are gated by rst so nothing transfers while in reset.
  assign input_ready  = r_in_ready & rst;
  assign output_valid = r_out_valid & rst;
  assign output_data  = r_result;

  assign w_in_hs  = input_valid & input_ready;
  assign w_out_hs = output_valid & output_ready;

  // Extend the sample, form the running sum and derive the block result.
  always_comb begin
    if (IS_SIGNED != 0) begin
      w_sample_ext = {{ACC_COUNT_LOG{input_data[DATA_WIDTH-1]}}, input_data};
    end else begin
      w_sample_ext = {{ACC_COUNT_LOG{1'b0}}, input_data};
    end

    w_sum    = r_acc + w_sample_ext;
    w_biased = w_sum + ROUND_BIAS;

    // Arithmetic shift floors toward -inf for two's complement sums.
    if (IS_SIGNED != 0) begin
      w_shifted = $unsigned($signed(w_biased) >>> ACC_COUNT_LOG);
    end else begin
      w_shifted = w_biased >> ACC_COUNT_LOG;
    end

    if (OUTPUT_AVERAGE != 0) begin
      w_result = w_shifted[OUT_WIDTH-1:0];
    end else begin
      w_result = w_sum[OUT_WIDTH-1:0];
    end
  end

  // Block FSM: accumulate a block, then repeat its result; flags are registered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_ACCUM;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_rep       <= '0;
      r_result    <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (w_in_hs) begin
            if (r_cnt == CNT_LAST) begin
              // Last sample of the block: the result includes this sample.
              r_result    <= w_result;
              r_acc       <= '0;
              r_cnt       <= '0;
              r_state     <= ST_OUTPUT;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end else begin
              r_acc <= w_sum;
              r_cnt <= r_cnt + CNT_ONE;
            end
          end else begin
            r_acc <= r_acc;
          end
        end
        ST_OUTPUT: begin
          if (w_out_hs) begin
            if (r_rep == REP_LAST) begin
              r_rep       <= '0;
              r_state     <= ST_ACCUM;
              r_in_ready  <= 1'b1;
              r_out_valid <= 1'b0;
            end else begin
              r_rep <= r_rep + REP_ONE;
            end
          end else begin
            r_rep <= r_rep;
          end
        end
        default: begin
          r_state     <= ST_ACCUM;
          r_acc       <= '0;
          r_cnt       <= '0;
          r_rep       <= '0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_block_avg_repeater.sv
// ---------------------------------------------------------------------------
// tb_axis_block_avg_repeater
//
// Four instances with ACC_COUNT_LOG=2, DATA_WIDTH=16:
//   0: unsigned average, 1 repetition
//   1: signed average,   1 repetition
//   2: unsigned sum,     1 repetition (18-bit output)
//   3: unsigned average, 7 repetitions
// Directed cases plus random blocks compared against an arithmetic model.
// ---------------------------------------------------------------------------
module tb_axis_block_avg_repeater;

  localparam logic [3:0] CFG_SIGNED = 4'b0010;
  localparam logic [3:0] CFG_AVG    = 4'b1011;
`ifdef AXIS_BLOCK_AVG_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  typedef logic [15:0] blk_t [4];

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [3:0]       in_valid;
  logic [3:0]       out_ready;
  logic [3:0][15:0] in_data;
  wire  [3:0]       in_ready;
  wire  [3:0]       out_valid;
  wire  [3:0][17:0] out_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int OW = CFG_AVG[g] ? 16 : 18;
    logic [OW-1:0] w_od;
    axis_block_avg_repeater #(
      .DATA_WIDTH(16),
      .ACC_COUNT_LOG(2),
      .IS_SIGNED(int'(CFG_SIGNED[g])),
      .OUTPUT_AVERAGE(int'(CFG_AVG[g])),
      .NUMBER_OF_REPETITIONS((g == 3) ? 7 : 1)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .input_valid(in_valid[g]),
      .input_ready(in_ready[g]),
      .input_data(in_data[g]),
      .output_valid(out_valid[g]),
      .output_ready(out_ready[g]),
      .output_data(w_od)
    );
    assign out_data[g] = 18'(w_od);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer sum of the block, then floor divide (or round).
  function automatic logic [17:0] model(input int k, input blk_t s);
    longint sum = 0;
    for (int i = 0; i < 4; i++) begin
      if (CFG_SIGNED[k]) sum += longint'($signed(s[i]));
      else               sum += longint'(s[i]);
    end
    if (CFG_AVG[k]) begin
      if (ROUND) sum += 2;
      sum = sum >>> 2;
      return {2'b00, sum[15:0]};
    end
    return sum[17:0];
  endfunction

  // Present a block with random gaps; ends on the negedge after the last accept.
  task automatic feed(input int k, input blk_t s, input int gap_pct);
    int idx = 0;
    int cyc = 0;
    while (idx < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      chk("no_valid_while_accum", out_valid[k], 1'b0);
      if (int'($urandom_range(99)) >= gap_pct) begin
        in_valid[k] = 1'b1;
        in_data[k]  = s[idx];
      end else begin
        in_valid[k] = 1'b0;
        in_data[k]  = 16'($urandom);
      end
      if (in_valid[k] && in_ready[k]) idx++;
    end
    chk("feed_accepted", idx, 4);
    @(negedge clk);
    in_valid[k] = 1'b0;
    chk("latency_valid", out_valid[k], 1'b1);
    chk("ready_low_after_block", in_ready[k], 1'b0);
  endtask

  // Consume all repetitions with random stalls, checking value every cycle.
  task automatic drain(input int k, input logic [17:0] exp, input int reps, input int stall_pct);
    int beats = 0;
    int cyc = 0;
    while (beats < reps && cyc < 400) begin
      chk("out_valid", out_valid[k], 1'b1);
      chk("out_data", out_data[k], exp);
      chk("in_ready_low", in_ready[k], 1'b0);
      if (!out_valid[k]) break;
      out_ready[k] = (int'($urandom_range(99)) >= stall_pct);
      if (out_ready[k]) beats++;
      @(negedge clk);
      cyc++;
    end
    out_ready[k] = 1'b0;
    chk("beat_count", beats, reps);
    chk("valid_dropped", out_valid[k], 1'b0);
    chk("ready_restored", in_ready[k], 1'b1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    blk_t b;
    int idx;
    int cyc;
    in_valid  = '0;
    out_ready = '0;
    in_data   = '0;
    rst       = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk("reset_in_ready", in_ready[k], 1'b0);
      chk("reset_out_valid", out_valid[k], 1'b0);
    end
    rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk("post_reset_ready", in_ready[k], 1'b1);
      chk("post_reset_data", out_data[k], 18'd0);
    end

    // Unsigned average 1,2,3,4
    b = '{16'd1, 16'd2, 16'd3, 16'd4};
    feed(0, b, 0);
    drain(0, ROUND ? 18'd3 : 18'd2, 1, 0);

    // Signed average -1..-4
    b = '{16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFC};
    feed(1, b, 0);
    drain(1, ROUND ? 18'h0FFFE : 18'h0FFFD, 1, 0);

    // Full-width sum, no overflow
    b = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    feed(2, b, 0);
    drain(2, 18'h3FFFC, 1, 0);

    // Seven repetitions under random backpressure
    b = '{16'd10, 16'd20, 16'd30, 16'd40};
    feed(3, b, 30);
    drain(3, 18'd25, 7, 50);

    // Gapped input, result held 10 cycles while the next block waits
    b = '{16'd7, 16'd9, 16'd11, 16'd13};
    feed(0, b, 50);
    for (int i = 0; i < 10; i++) begin
      in_valid[0] = 1'b1;
      in_data[0]  = 16'd5;
      chk("hold_valid", out_valid[0], 1'b1);
      chk("hold_data", out_data[0], 18'd10);
      chk("hold_block_input", in_ready[0], 1'b0);
      @(negedge clk);
    end
    in_valid[0] = 1'b0;
    drain(0, 18'd10, 1, 0);
    b = '{16'd5, 16'd5, 16'd5, 16'd5};
    feed(0, b, 40);
    drain(0, 18'd5, 1, 0);

    // Reset after a partial block discards it
    idx = 0;
    cyc = 0;
    while (idx < 2 && cyc < 50) begin
      @(negedge clk);
      cyc++;
      in_valid[0] = 1'b1;
      in_data[0]  = (idx == 0) ? 16'd100 : 16'd200;
      if (in_ready[0]) idx++;
    end
    chk("partial_accepted", idx, 2);
    @(negedge clk);
    in_valid[0] = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("midblock_reset_ready", in_ready[0], 1'b0);
    chk("midblock_reset_valid", out_valid[0], 1'b0);
    @(negedge clk);
    rst = 1'b1;
    b = '{16'd8, 16'd8, 16'd8, 16'd8};
    feed(0, b, 20);
    drain(0, 18'd8, 1, 0);

    // Random blocks on every instance
    for (int it = 0; it < 16; it++) begin
      int k;
      k = it % 4;
      for (int i = 0; i < 4; i++) b[i] = 16'($urandom);
      feed(k, b, int'($urandom_range(50)));
      drain(k, model(k, b), (k == 3) ? 7 : 1, int'($urandom_range(60)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
